// File: rtl/chacha_pkg.sv
`default_nettype none
// ============================================================================
// chacha_pkg : constants and state encoding shared by the ChaCha state loader
// Revision   : 1.0
// ============================================================================
package chacha_pkg;

  // "expand 32-byte k" as four little-endian words
  localparam logic [31:0] SIGMA0 = 32'h6170_7865;
  localparam logic [31:0] SIGMA1 = 32'h3320_646e;
  localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

  localparam logic [3:0] KEY_FIRST = 4'd4;
  localparam logic [3:0] CTR_IDX   = 4'd12;
  localparam logic [3:0] LAST_IDX  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONST = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  function automatic logic [31:0] sigma_word(input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = SIGMA0;
      2'd1:    w = SIGMA1;
      2'd2:    w = SIGMA2;
      default: w = SIGMA3;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chacha_state_loader.sv
`default_nettype none
// ============================================================================
// chacha_state_loader : writes sigma, then 12 streamed key/counter/nonce words,
//                       into the ChaCha working state; can bump the counter.
// Revision            : 1.0
// ============================================================================
module chacha_state_loader
  import chacha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              next_blk,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [3:0]        wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              loaded,
  output logic              done
);

  state_e            state_q;
  logic [3:0]        idx_q;
  logic [WORD_W-1:0] ctr_q;
  logic [WORD_W-1:0] ctr_d;
  logic [WORD_W-1:0] sigma_d;
  logic [3:0]        wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic              wr_en_q;
  logic              done_q;
  logic              loaded_q;

  always_comb begin
    ctr_d   = ctr_q + WORD_W'(1);
    sigma_d = WORD_W'(sigma_word(idx_q[1:0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      ctr_q     <= '0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Word 0 goes out straight from IDLE so the constants fill t+1..t+4.
            state_q   <= ST_CONST;
            loaded_q  <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= 4'd0;
            wr_data_q <= WORD_W'(SIGMA0);
            idx_q     <= 4'd1;
          end else if (next_blk && loaded_q) begin
            ctr_q     <= ctr_d;
            wr_en_q   <= 1'b1;
            wr_addr_q <= CTR_IDX;
            wr_data_q <= ctr_d;
            done_q    <= 1'b1;
          end
        end
        ST_CONST: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= idx_q;
          wr_data_q <= sigma_d;
          idx_q     <= idx_q + 4'd1;
          if (idx_q == KEY_FIRST - 4'd1) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            wr_data_q <= in_data;
            if (idx_q == CTR_IDX) begin
              ctr_q <= in_data;
            end
            if (idx_q == LAST_IDX) begin
              state_q  <= ST_IDLE;
              idx_q    <= 4'd0;
              loaded_q <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign done     = done_q;
  assign loaded   = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_chacha_state_loader.sv
`default_nettype none
// ============================================================================
// tb_chacha_state_loader : directed self-checking bench for chacha_state_loader
// Revision               : 1.0
// ============================================================================
module tb_chacha_state_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        next_blk;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        busy;
  logic        loaded;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] kw    [12];
  logic [31:0] sigma [4];

  chacha_state_loader #(.WORD_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .next_blk (next_blk),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .loaded   (loaded),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words();
    for (int i = 0; i < 12; i++) begin
      kw[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end
  endtask

  // Full load; with_nb raises next_blk alongside start, gap throttles in_valid
  // and pokes start/next_blk on the idle cycles of LOAD.
  task automatic full_load(input bit gap, input bit with_nb);
    int j;
    int cyc;
    bit v;
    start    = 1'b1;
    next_blk = with_nb;
    tick();
    start    = 1'b0;
    next_blk = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_clr_loaded", 32'(loaded), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("c%0d_en", k), 32'(wr_en), 32'd1);
      chk($sformatf("c%0d_addr", k), 32'(wr_addr), 32'(k));
      chk($sformatf("c%0d_data", k), wr_data, sigma[k]);
      chk($sformatf("c%0d_rdy", k), 32'(in_ready), (k == 3) ? 32'd1 : 32'd0);
      if (k < 3) tick();
    end
    j   = 0;
    cyc = 0;
    while (j < 12 && cyc < 64) begin
      v        = gap ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      in_data  = v ? kw[j] : 32'hDEAD_BEEF;
      start    = gap && !v;
      next_blk = gap && !v;
      tick();
      cyc++;
      if (v) begin
        chk($sformatf("w%0d_en", 4 + j), 32'(wr_en), 32'd1);
        chk($sformatf("w%0d_addr", 4 + j), 32'(wr_addr), 32'(4 + j));
        chk($sformatf("w%0d_data", 4 + j), wr_data, kw[j]);
        chk($sformatf("w%0d_done", 4 + j), 32'(done), (j == 11) ? 32'd1 : 32'd0);
        j++;
      end else begin
        chk("gap_no_wr", 32'(wr_en), 32'd0);
        chk("gap_addr_hold", 32'(wr_addr), 32'(3 + j));
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    next_blk = 1'b0;
    chk("load_finished_in_budget", 32'(j), 32'd12);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_loaded", 32'(loaded), 32'd1);
    chk("end_rdy", 32'(in_ready), 32'd0);
  endtask

  task automatic bump(input logic [31:0] exp_ctr);
    next_blk = 1'b1;
    tick();
    next_blk = 1'b0;
    chk("nb_en", 32'(wr_en), 32'd1);
    chk("nb_addr", 32'(wr_addr), 32'd12);
    chk("nb_data", wr_data, exp_ctr);
    chk("nb_done", 32'(done), 32'd1);
    chk("nb_busy", 32'(busy), 32'd0);
    tick();
    chk("nb_after_en", 32'(wr_en), 32'd0);
    chk("nb_after_addr", 32'(wr_addr), 32'd12);
    chk("nb_after_done", 32'(done), 32'd0);
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sigma[0] = 32'h6170_7865;
    sigma[1] = 32'h3320_646e;
    sigma[2] = 32'h7962_2d32;
    sigma[3] = 32'h6b20_6574;
    rst_n    = 1'b0;
    start    = 1'b0;
    next_blk = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);

    // Counter bump before any load must be ignored.
    next_blk = 1'b1;
    tick();
    next_blk = 1'b0;
    expect_quiet("nb_unloaded");

    // Back-to-back load of 0x00010203...; word 12 = 0x20212223.
    fill_words();
    full_load(1'b0, 1'b0);
    bump(32'h2021_2224);

    // Throttled load started together with next_blk; word 12 = 7.
    fill_words();
    kw[8] = 32'h0000_0007;
    full_load(1'b1, 1'b1);
    bump(32'h0000_0008);

    // Counter wrap.
    kw[8] = 32'hFFFF_FFFF;
    full_load(1'b0, 1'b0);
    bump(32'h0000_0000);
    bump(32'h0000_0001);

    // Asynchronous reset after 8 handshakes.
    fill_words();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_rdy", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = kw[i];
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_addr", 32'(wr_addr), 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(wr_en), 32'd0);
    chk("arst_addr", 32'(wr_addr), 32'd0);
    chk("arst_data", wr_data, 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    next_blk = 1'b1;
    tick();
    next_blk = 1'b0;
    expect_quiet("nb_after_rst");
    full_load(1'b0, 1'b0);
    bump(32'h2021_2224);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha_state_loader.md
# chacha_state_loader

Sequencer that fills the 16-word ChaCha20 working state before each block computation. It writes the four sigma constants, then accepts 12 key/counter/nonce words over a valid/ready stream. It drives a 4-bit word index that the downstream 4-to-16 one-hot decoder turns into per-word write enables. After a full load it can also re-issue only the block-counter word (index 12), incremented, for the next keystream block.

## Interface

Parameters:
- WORD_W, 32, state word width. Constants are truncated to the low WORD_W bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  pulse; begins a full load (words 0..15)
- next_blk  input  1  pulse; rewrites word 12 with the stored counter + 1
- in_data  input  WORD_W  key/counter/nonce word
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data this cycle
- wr_addr  output  4  word index; feeds the one-hot decoder
- wr_data  output  WORD_W  word to store at wr_addr
- wr_en  output  1  write strobe for wr_addr/wr_data
- busy  output  1  full load in progress
- loaded  output  1  a complete 16-word load has finished since reset
- done  output  1  one-cycle pulse coincident with the final write of a full load or a next_blk update

## Operation

- FSM states: IDLE, CONST, LOAD.
- IDLE:
  - start=1 → CONST, with word index 0 issued.
  - start=0, next_blk=1 and loaded=1 → counter-update write. No state change.
  - Anything else → stay in IDLE.
- CONST: issues sigma words 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574 at indices 0..3, one per cycle. Moves to LOAD after index 3.
- LOAD:
  - in_ready=1 only in this state (combinational on state).
  - Each handshake (in_valid & in_ready) writes in_data to the next index, 4..15 in order.
  - The handshake at index 12 also captures in_data into the internal counter register.
  - Handshake at index 15 → IDLE, loaded←1, done pulse.
- Counter update: ctr ← ctr + 1 mod 2^WORD_W (0xFFFFFFFF wraps to 0x00000000). Writes the new value at index 12 with a done pulse.
- Simultaneous events:
  - start and next_blk in the same cycle: start wins, next_blk is dropped.
  - start while busy is ignored.
  - next_blk while busy, or while loaded=0, is ignored.
  - A new start clears loaded until the new load completes.
- in_valid outside LOAD has no effect; data is not buffered.
- Reset (asynchronous, mid-operation included):
  - state=IDLE, index=0, ctr=0.
  - wr_en=0, wr_addr=0, wr_data=0, done=0, loaded=0, in_ready=0, busy=0.
  - A partial load is abandoned.

## Timing

- wr_en, wr_addr, wr_data and done are registered. busy = (state != IDLE).
- start sampled high in cycle t:
  - Constant writes appear in cycles t+1..t+4 (wr_addr 0..3).
  - State is LOAD and in_ready=1 from cycle t+4.
- Handshake in cycle u → write visible in u+1 with wr_addr = word index.
- Back-to-back handshakes give one write per cycle, so a full load takes a minimum of 16 cycles after start.
- Final handshake (index 15) in cycle u → in cycle u+1: wr_addr=15, done=1, busy=0, loaded=1.
- next_blk accepted in cycle t → in cycle t+1: wr_en=1, wr_addr=12, wr_data=ctr+1, done=1.
- wr_en is low in every cycle without a write, and wr_addr holds its last value then.

## Structure

- Shared package chacha_pkg holds:
  - SIGMA0..SIGMA3 constants.
  - Index constants KEY_FIRST=4, CTR_IDX=12, LAST_IDX=15.
  - FSM state encoding.
- No sub-module. The one-hot decoder sits outside as the consumer of wr_addr.

## Test plan

- Reset, then start with 12 back-to-back words 0x00010203…:
  - writes at addr 0..15 in order, contiguous from t+1;
  - words 0..3 equal sigma;
  - done and loaded set at the addr-15 write.
- in_valid toggled every other cycle during LOAD → writes only on handshake cycles, indices contiguous, no duplicates.
- After a load with word12=0x00000007, pulse next_blk → next cycle addr 12, data 0x00000008, done=1. Repeat from 0xFFFFFFFF → data 0x00000000.
- next_blk before any load, next_blk during busy, and start during LOAD → no write, no state change. start together with next_blk in IDLE → full load only.
- Assert rst_n low after 8 handshakes:
  - all outputs zero immediately, loaded=0;
  - a subsequent next_blk is ignored;
  - a subsequent start reloads from addr 0.
